// File: rtl/video_pkg.sv
// Shared video constants and pipeline flag types for the pixel fetch path.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package video_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int BG_AW  = 17;
  localparam int SPR_AW = 12;

  // Area palette index that lets the forest background show through.
  localparam logic [2:0] TRANSPARENT_IDX = 3'b000;

  // Per-pixel flags that travel alongside the ROM requests.
  typedef struct packed {
    logic vld;
    logic hit;
  } pix_flags_t;

endpackage

// File: rtl/sprite_hit.sv
// Sprite hit test: pixel offset from the sprite corner and in-box decision.
// Latency: combinational, 0 cycles.
// Backpressure: none; evaluates every cycle.
module sprite_hit
  import video_pkg::*;
#(
  parameter int SPR_SIZE = 32
) (
  input  logic        pix_valid,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic [9:0]  spr_x,
  input  logic [9:0]  spr_y,
  output logic        hit,
  output logic [10:0] dx,
  output logic [10:0] dy
);

  // 11-bit differences: a borrow sets bit 10, which can never be below
  // SPR_SIZE, so pixels left of / above the sprite never hit. Pixels past
  // the screen edge never arrive, so the sprite is clipped without wrap.
  always_comb begin
    dx  = {1'b0, draw_x} - {1'b0, spr_x};
    dy  = {1'b0, draw_y} - {1'b0, spr_y};
    hit = pix_valid && (dx < 11'(SPR_SIZE)) && (dy < 11'(SPR_SIZE));
  end

endmodule

// File: rtl/pixel_index_fetch.sv
// Background/sprite palette index fetch: ROM addressing, hit, transparency.
// Latency: 3 cycles from DrawX/DrawY to IDX_VALID; ROM addresses 1 cycle.
// Backpressure: none; one pixel accepted every cycle, no stalls.
module pixel_index_fetch
  import video_pkg::*;
#(
  parameter int BG_W     = 320,
  parameter int SPR_SIZE = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pix_valid,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              frame_start,
  input  logic [9:0]        sprite_x_in,
  input  logic [9:0]        sprite_y_in,
  input  logic [1:0]        sprite_frame_in,
  output logic [BG_AW-1:0]  bg_rom_addr,
  input  logic [3:0]        bg_rom_data,
  output logic [SPR_AW-1:0] spr_rom_addr,
  input  logic [2:0]        spr_rom_data,
  output logic              IDX_VALID,
  output logic [3:0]        FOREST_IDX,
  output logic [2:0]        AREA_IDX,
  output logic              SEL_AREA
);

  logic [9:0]  spr_x;
  logic [9:0]  spr_y;
  logic [1:0]  spr_frame;

  logic        hit;
  logic [10:0] dx;
  logic [10:0] dy;

  logic [BG_AW-1:0]  bg_addr_nxt;
  logic [SPR_AW-1:0] spr_addr_nxt;

  pix_flags_t  s0_flags;
  pix_flags_t  s1_flags;

  sprite_hit #(
    .SPR_SIZE (SPR_SIZE)
  ) u_sprite_hit (
    .pix_valid (pix_valid),
    .draw_x    (DrawX),
    .draw_y    (DrawY),
    .spr_x     (spr_x),
    .spr_y     (spr_y),
    .hit       (hit),
    .dx        (dx),
    .dy        (dy)
  );

  // Background texels are 2x2 screen pixels; sprite frames are stacked
  // SPR_SIZE^2 apart in the sprite ROM, row-major inside each frame.
  always_comb begin
    bg_addr_nxt  = BG_AW'(DrawY >> 1) * BG_AW'(BG_W) + BG_AW'(DrawX >> 1);
    spr_addr_nxt = SPR_AW'(spr_frame) * SPR_AW'(SPR_SIZE * SPR_SIZE)
                 + SPR_AW'(dy) * SPR_AW'(SPR_SIZE)
                 + SPR_AW'(dx);
  end

  // Sprite position shadow: only reloaded at vertical blank so a frame is
  // drawn with one consistent position; the load cycle still uses old values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      spr_x     <= '0;
      spr_y     <= '0;
      spr_frame <= '0;
    end else if (frame_start) begin
      spr_x     <= sprite_x_in;
      spr_y     <= sprite_y_in;
      spr_frame <= sprite_frame_in;
    end
  end

  // S0: register ROM addresses and the pixel flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bg_rom_addr  <= '0;
      spr_rom_addr <= '0;
      s0_flags     <= '0;
    end else begin
      bg_rom_addr  <= bg_addr_nxt;
      spr_rom_addr <= hit ? spr_addr_nxt : '0;
      s0_flags     <= '{vld: pix_valid, hit: hit};
    end
  end

  // S1: flags wait one cycle while the ROMs return data.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_flags <= '0;
    end else begin
      s1_flags <= s0_flags;
    end
  end

  // S2: register indices; invisible pixels drive all-zero outputs.
  always_ff @(posedge Clk) begin
    if (Reset || !s1_flags.vld) begin
      IDX_VALID  <= 1'b0;
      FOREST_IDX <= '0;
      AREA_IDX   <= '0;
      SEL_AREA   <= 1'b0;
    end else begin
      IDX_VALID  <= 1'b1;
      FOREST_IDX <= bg_rom_data;
      AREA_IDX   <= spr_rom_data;
      SEL_AREA   <= s1_flags.hit && (spr_rom_data != TRANSPARENT_IDX);
    end
  end

endmodule

// File: tb/tb_pixel_index_fetch.sv
// Bench for pixel_index_fetch: vector table plus corner-case sequences.
// Expected addresses are hand-computed constants; indices come from ROM models.
// A scoreboard queues expectations with the cycle they are due.
module tb_pixel_index_fetch;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        pix_valid;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        frame_start;
  logic [9:0]  sprite_x_in;
  logic [9:0]  sprite_y_in;
  logic [1:0]  sprite_frame_in;
  logic [16:0] bg_rom_addr;
  logic [3:0]  bg_rom_data;
  logic [11:0] spr_rom_addr;
  logic [2:0]  spr_rom_data;
  logic        IDX_VALID;
  logic [3:0]  FOREST_IDX;
  logic [2:0]  AREA_IDX;
  logic        SEL_AREA;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  bit       spr_force_en = 1'b0;
  logic [2:0] spr_force  = 3'd0;
  bit       end_chk  = 1'b0;
  bit       end_done = 1'b0;

  typedef struct {
    int          due;
    logic [16:0] bg;
    logic [11:0] spr;
  } aexp_t;

  typedef struct {
    int         due;
    logic       vld;
    logic [3:0] forest;
    logic [2:0] area;
    logic       sel;
  } oexp_t;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        v;
    logic [16:0] bg;
    logic [11:0] spr;
    logic        hit;
  } vec_t;

  aexp_t addr_q[$];
  oexp_t out_q[$];
  aexp_t mon_a;
  oexp_t mon_o;
  vec_t  vt[12];

  pixel_index_fetch #(
    .BG_W     (320),
    .SPR_SIZE (32)
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .pix_valid       (pix_valid),
    .DrawX           (DrawX),
    .DrawY           (DrawY),
    .frame_start     (frame_start),
    .sprite_x_in     (sprite_x_in),
    .sprite_y_in     (sprite_y_in),
    .sprite_frame_in (sprite_frame_in),
    .bg_rom_addr     (bg_rom_addr),
    .bg_rom_data     (bg_rom_data),
    .spr_rom_addr    (spr_rom_addr),
    .spr_rom_data    (spr_rom_data),
    .IDX_VALID       (IDX_VALID),
    .FOREST_IDX      (FOREST_IDX),
    .AREA_IDX        (AREA_IDX),
    .SEL_AREA        (SEL_AREA)
  );

  always #5 Clk = ~Clk;

  function automatic logic [3:0] bg_f(input logic [16:0] a);
    return a[3:0] ^ a[11:8];
  endfunction

  function automatic logic [2:0] spr_f(input logic [11:0] a);
    return a[2:0] ^ a[5:3] ^ a[8:6] ^ a[11:9];
  endfunction

  // Synchronous ROM models: data one cycle after address.
  always @(posedge Clk) begin
    bg_rom_data  <= bg_f(bg_rom_addr);
    spr_rom_data <= spr_force_en ? spr_force : spr_f(spr_rom_addr);
  end

  always @(posedge Clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge Clk) begin
    while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
      mon_a = addr_q.pop_front();
      tests++;
      if (mon_a.due != cyc || bg_rom_addr !== mon_a.bg || spr_rom_addr !== mon_a.spr) begin
        fails++;
        $display("FAIL addr cyc=%0d due=%0d: got bg=%0d spr=%0d, want bg=%0d spr=%0d",
                 cyc, mon_a.due, bg_rom_addr, spr_rom_addr, mon_a.bg, mon_a.spr);
      end
    end
    while (out_q.size() > 0 && out_q[0].due <= cyc) begin
      mon_o = out_q.pop_front();
      tests++;
      if (mon_o.due != cyc || IDX_VALID !== mon_o.vld || FOREST_IDX !== mon_o.forest ||
          AREA_IDX !== mon_o.area || SEL_AREA !== mon_o.sel) begin
        fails++;
        $display("FAIL idx cyc=%0d due=%0d: got vld=%b forest=%0d area=%0d sel=%b, want vld=%b forest=%0d area=%0d sel=%b",
                 cyc, mon_o.due, IDX_VALID, FOREST_IDX, AREA_IDX, SEL_AREA,
                 mon_o.vld, mon_o.forest, mon_o.area, mon_o.sel);
      end
    end
    if (end_chk && !end_done) begin
      end_done = 1'b1;
      tests++;
      if (addr_q.size() != 0 || out_q.size() != 0) begin
        fails++;
        $display("FAIL drain: got %0d/%0d pending entries, want 0/0", addr_q.size(), out_q.size());
      end
    end
  end

  // Drive one pixel and queue its expected address and index results.
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic v,
                     input logic fs, input logic [16:0] ebg, input logic [11:0] espr,
                     input logic ehit);
    logic [2:0] sv;
    aexp_t a;
    oexp_t o;
    @(posedge Clk);
    #2;
    DrawX       = x;
    DrawY       = y;
    pix_valid   = v;
    frame_start = fs;
    sv = spr_force_en ? spr_force : spr_f(espr);
    a.due = cyc + 1;
    a.bg  = ebg;
    a.spr = espr;
    addr_q.push_back(a);
    o.due    = cyc + 3;
    o.vld    = v;
    o.forest = v ? bg_f(ebg) : 4'd0;
    o.area   = v ? sv : 3'd0;
    o.sel    = v & ehit & (sv != 3'd0);
    out_q.push_back(o);
  endtask

  task automatic flush();
    repeat (4) pix(10'd0, 10'd0, 1'b0, 1'b0, 17'd0, 12'd0, 1'b0);
  endtask

  // Reset while pixels are in flight: everything reads zero the next cycle
  // and IDX_VALID stays low until fresh pixels reach the output.
  task automatic do_reset();
    aexp_t a;
    oexp_t o;
    @(posedge Clk);
    #2;
    Reset = 1'b1;
    addr_q.delete();
    out_q.delete();
    a.due = cyc + 1; a.bg = 17'd0; a.spr = 12'd0;
    addr_q.push_back(a);
    for (int i = 1; i <= 4; i++) begin
      o.due = cyc + i; o.vld = 1'b0; o.forest = 4'd0; o.area = 3'd0; o.sel = 1'b0;
      out_q.push_back(o);
    end
    @(posedge Clk);
    #2;
    Reset       = 1'b0;
    pix_valid   = 1'b0;
    DrawX       = 10'd0;
    DrawY       = 10'd0;
    frame_start = 1'b0;
    a.due = cyc + 1; a.bg = 17'd0; a.spr = 12'd0;
    addr_q.push_back(a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Sprite latched at (100,50), frame 2 for these vectors.
    vt[0]  = '{x: 10'd5,   y: 10'd3,   v: 1'b1, bg: 17'd322,   spr: 12'd0,    hit: 1'b0};
    vt[1]  = '{x: 10'd110, y: 10'd60,  v: 1'b1, bg: 17'd9655,  spr: 12'd2378, hit: 1'b1};
    vt[2]  = '{x: 10'd100, y: 10'd50,  v: 1'b1, bg: 17'd8050,  spr: 12'd2048, hit: 1'b1};
    vt[3]  = '{x: 10'd131, y: 10'd81,  v: 1'b1, bg: 17'd12865, spr: 12'd3071, hit: 1'b1};
    vt[4]  = '{x: 10'd132, y: 10'd60,  v: 1'b1, bg: 17'd9666,  spr: 12'd0,    hit: 1'b0};
    vt[5]  = '{x: 10'd110, y: 10'd82,  v: 1'b1, bg: 17'd13175, spr: 12'd0,    hit: 1'b0};
    vt[6]  = '{x: 10'd99,  y: 10'd60,  v: 1'b1, bg: 17'd9649,  spr: 12'd0,    hit: 1'b0};
    vt[7]  = '{x: 10'd639, y: 10'd479, v: 1'b1, bg: 17'd76799, spr: 12'd0,    hit: 1'b0};
    vt[8]  = '{x: 10'd0,   y: 10'd0,   v: 1'b1, bg: 17'd0,     spr: 12'd0,    hit: 1'b0};
    vt[9]  = '{x: 10'd110, y: 10'd60,  v: 1'b0, bg: 17'd9655,  spr: 12'd0,    hit: 1'b0};
    vt[10] = '{x: 10'd120, y: 10'd70,  v: 1'b1, bg: 17'd11260, spr: 12'd2708, hit: 1'b1};
    vt[11] = '{x: 10'd638, y: 10'd1,   v: 1'b1, bg: 17'd319,   spr: 12'd0,    hit: 1'b0};

    Reset           = 1'b1;
    pix_valid       = 1'b0;
    DrawX           = 10'd0;
    DrawY           = 10'd0;
    frame_start     = 1'b0;
    sprite_x_in     = 10'd100;
    sprite_y_in     = 10'd50;
    sprite_frame_in = 2'd2;

    do_reset();

    // Latch sprite; this cycle still sees the reset shadow (0,0).
    pix(10'd0, 10'd0, 1'b0, 1'b1, 17'd0, 12'd0, 1'b0);
    for (int i = 0; i < 12; i++)
      pix(vt[i].x, vt[i].y, vt[i].v, 1'b0, vt[i].bg, vt[i].spr, vt[i].hit);
    flush();

    // Opaque sprite texel selects the area palette; index 0 is transparent.
    spr_force_en = 1'b1;
    spr_force    = 3'b101;
    pix(10'd110, 10'd60, 1'b1, 1'b0, 17'd9655, 12'd2378, 1'b1);
    flush();
    spr_force    = 3'b000;
    pix(10'd110, 10'd60, 1'b1, 1'b0, 17'd9655, 12'd2378, 1'b1);
    flush();
    spr_force_en = 1'b0;

    // Sprite at the right edge: clipped, no wrap to column 0.
    sprite_x_in = 10'd630;
    pix(10'd0, 10'd0, 1'b0, 1'b1, 17'd0, 12'd0, 1'b0);
    pix(10'd639, 10'd60, 1'b1, 1'b0, 17'd9919, 12'd2377, 1'b1);
    for (int x = 0; x <= 5; x++)
      pix(10'(x), 10'd60, 1'b1, 1'b0, 17'(9600 + x / 2), 12'd0, 1'b0);

    // Mid-frame position change is ignored until after frame_start.
    sprite_x_in = 10'd100;
    pix(10'd110, 10'd60, 1'b1, 1'b0, 17'd9655, 12'd0, 1'b0);
    pix(10'd110, 10'd60, 1'b1, 1'b1, 17'd9655, 12'd0, 1'b0);
    pix(10'd110, 10'd60, 1'b1, 1'b0, 17'd9655, 12'd2378, 1'b1);
    // Borrow case: sprite at 120, pixel at 100.
    sprite_x_in = 10'd120;
    pix(10'd639, 10'd60, 1'b1, 1'b1, 17'd9919, 12'd0, 1'b0);
    pix(10'd100, 10'd60, 1'b1, 1'b0, 17'd9650, 12'd0, 1'b0);
    pix(10'd125, 10'd60, 1'b1, 1'b0, 17'd9662, 12'd2373, 1'b1);

    // Reset mid-line with pixels in flight; shadow returns to (0,0), frame 0.
    pix(10'd110, 10'd60, 1'b1, 1'b0, 17'd9655, 12'd0, 1'b0);
    pix(10'd111, 10'd60, 1'b1, 1'b0, 17'd9655, 12'd0, 1'b0);
    do_reset();
    pix(10'd0, 10'd0, 1'b0, 1'b0, 17'd0, 12'd0, 1'b0);
    pix(10'd0, 10'd0, 1'b0, 1'b0, 17'd0, 12'd0, 1'b0);
    pix(10'd10, 10'd10, 1'b1, 1'b0, 17'd1605, 12'd330, 1'b1);
    flush();

    repeat (3) @(posedge Clk);
    end_chk = 1'b1;
    repeat (2) @(posedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
